// File: rtl/unit_clause_tracker_if.sv
// unit_clause_tracker_if: control (load/set/delete/save/restore), pop handshake (out_valid/out_var/out_ready) and status (unit_clause/count/level/overflow/underflow) bundle
interface unit_clause_tracker_if #(
  parameter int W = 8,
  parameter int NDEL = 2,
  parameter int DEPTH = 4
);
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W + 1);
  localparam int SW = $clog2(DEPTH + 1);
  logic load_en;
  logic [W-1:0] load_data;
  logic [W-1:0] set_mask;
  logic [NDEL-1:0] del_en;
  logic [NDEL*IW-1:0] del_var;
  logic save;
  logic restore;
  logic [W-1:0] unit_clause;
  logic out_valid;
  logic [IW-1:0] out_var;
  logic out_ready;
  logic [CW-1:0] count;
  logic [SW-1:0] level;
  logic overflow;
  logic underflow;
  modport master (
    output load_en, load_data, set_mask, del_en, del_var, save, restore, out_ready,
    input unit_clause, out_valid, out_var, count, level, overflow, underflow
  );
  modport slave (
    input load_en, load_data, set_mask, del_en, del_var, save, restore, out_ready,
    output unit_clause, out_valid, out_var, count, level, overflow, underflow
  );
endinterface

// File: rtl/unit_clause_tracker.sv
// unit_clause_tracker: pending unit-clause vector with set/delete/pop/load and a save/restore stack; ports clk, rst (async high), bus (slave)
module unit_clause_tracker #(
  parameter int W = 8,
  parameter int NDEL = 2,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  unit_clause_tracker_if.slave bus
);
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W + 1);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] uc, clr, nxt;
  logic [W-1:0] stack [DEPTH];
  logic [SW-1:0] lvl, lm1;
  logic ovf, udf;
  logic [IW-1:0] low;
  logic [CW-1:0] pc;
  logic pop, full, can_pop;
  assign lm1 = lvl - SW'(1);
  assign full = lvl == SW'(DEPTH);
  assign can_pop = lvl != '0;
  assign pop = |uc && bus.out_ready;
  always_comb begin
    low = '0;
    for (int i = W - 1; i >= 0; i--) low = uc[i] ? IW'(i) : low;
    pc = '0;
    for (int i = 0; i < W; i++) pc = pc + CW'(uc[i]);
    clr = '0;
    for (int k = 0; k < NDEL; k++)
      if (bus.del_en[k] && int'(bus.del_var[k*IW +: IW]) < W) clr[bus.del_var[k*IW +: IW]] = 1'b1;
    if (pop) clr[low] = 1'b1;
    nxt = bus.load_en ? bus.load_data : (uc | bus.set_mask) & ~clr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      uc <= '0;
      lvl <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (bus.restore && can_pop) begin
      uc <= stack[lm1[AW-1:0]];
      lvl <= lm1;
    end else begin
      uc <= nxt;
      if (bus.restore) udf <= 1'b1;
      else if (bus.save && full) ovf <= 1'b1;
      else if (bus.save) lvl <= lvl + SW'(1);
    end
  // Stack storage has no reset; entries only become readable once pushed.
  always_ff @(posedge clk)
    if (!rst && bus.save && !bus.restore && !full) stack[lvl[AW-1:0]] <= uc;
  assign bus.unit_clause = uc;
  assign bus.out_valid = |uc;
  assign bus.out_var = low;
  assign bus.count = pc;
  assign bus.level = lvl;
  assign bus.overflow = ovf;
  assign bus.underflow = udf;
endmodule

// File: tb/tb_unit_clause_tracker.sv
// tb_unit_clause_tracker: scoreboard bench with directed scenarios, async reset pulse and random stimulus against a queue-based model
module tb_unit_clause_tracker;
  localparam int W = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  logic [20:0] exp_q[$];
  string name_q[$];
  logic [7:0] m_uc;
  logic [7:0] m_stk[$];
  logic m_ovf, m_udf;
  unit_clause_tracker_if #(.W(8), .NDEL(2), .DEPTH(4)) bus ();
  unit_clause_tracker #(.W(8), .NDEL(2), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction
  function automatic logic [20:0] model_out();
    return {m_uc, 4'($countones(m_uc)), 3'(m_stk.size()), m_ovf, m_udf, m_uc != 0, lowest(m_uc)};
  endfunction
  function automatic logic [20:0] dut_out();
    return {bus.unit_clause, bus.count, bus.level, bus.overflow, bus.underflow, bus.out_valid, bus.out_var};
  endfunction
  task automatic cyc(input string nm, input logic le, input logic [7:0] ld, input logic [7:0] sm,
                     input logic [1:0] de, input logic [5:0] dv, input logic sv, input logic rs, input logic rdy);
    logic [7:0] nu;
    @(negedge clk);
    #1;
    bus.load_en = le; bus.load_data = ld; bus.set_mask = sm; bus.del_en = de; bus.del_var = dv;
    bus.save = sv; bus.restore = rs; bus.out_ready = rdy;
    if (rs && m_stk.size() > 0) m_uc = m_stk.pop_back();
    else begin
      if (le) nu = ld;
      else begin
        nu = m_uc | sm;
        for (int k = 0; k < 2; k++) if (de[k] && int'(dv[k*3 +: 3]) < W) nu[dv[k*3 +: 3]] = 1'b0;
        if (rdy && m_uc != 0) nu[lowest(m_uc)] = 1'b0;
      end
      if (rs) m_udf = 1'b1;
      else if (sv && m_stk.size() == DEPTH) m_ovf = 1'b1;
      else if (sv) m_stk.push_back(m_uc);
      m_uc = nu;
    end
    exp_q.push_back(model_out());
    name_q.push_back(nm);
  endtask
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      logic [20:0] e, g;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g = dut_out();
      total++;
      if (g !== e) $display("FAIL %s: got uc/cnt/lvl/ovf/udf/vld/var=%h expected %h", n, g, e);
      else passed++;
    end
  end
  initial begin
    bus.load_en = 0; bus.load_data = 0; bus.set_mask = 0; bus.del_en = 0; bus.del_var = 0;
    bus.save = 0; bus.restore = 0; bus.out_ready = 0;
    m_uc = 0; m_ovf = 0; m_udf = 0;
    exp_q.push_back(model_out());
    name_q.push_back("reset");
    @(negedge clk);
    #1 rst = 0;
    cyc("load_ff", 1, 8'hFF, 0, 0, 0, 0, 0, 0);
    cyc("dual_del", 0, 0, 0, 2'b11, {3'd6, 3'd2}, 0, 0, 0);
    cyc("load_28", 1, 8'h28, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("pop_seq", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("set_del_same", 0, 0, 8'h01, 2'b01, 6'd0, 0, 0, 0);
    cyc("dup_del_set", 0, 0, 8'h30, 2'b11, {3'd4, 3'd4}, 0, 0, 0);
    cyc("load_0f", 1, 8'h0F, 0, 0, 0, 0, 0, 0);
    cyc("save_0f", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("load_f0", 1, 8'hF0, 0, 0, 0, 0, 0, 0);
    cyc("restore_0f", 0, 0, 8'h01, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) cyc("save_x5", 0, 0, 8'(1 << i), 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc("restore_x5", 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("flags_hold", 0, 0, 8'h80, 0, 0, 0, 0, 0);
    cyc("load_aa", 1, 8'hAA, 0, 0, 0, 0, 0, 0);
    cyc("save_a", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("save_b", 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    bus.save = 0;
    rst = 1;
    #1;
    total++;
    if ({bus.unit_clause, bus.level, bus.overflow, bus.underflow, bus.out_valid, bus.count} !== '0)
      $display("FAIL async_reset: got uc=%h lvl=%0d ovf=%b udf=%b vld=%b cnt=%0d expected all zero",
               bus.unit_clause, bus.level, bus.overflow, bus.underflow, bus.out_valid, bus.count);
    else passed++;
    #1 rst = 0;
    m_uc = 0; m_ovf = 0; m_udf = 0; m_stk.delete();
    for (int i = 0; i < 400; i++)
      cyc("random", $urandom_range(0, 7) == 0, 8'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
          2'($urandom), 6'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, 1'($urandom));
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/unit_clause_tracker.md
UNIT_CLAUSE_TRACKER -- requirements
Module: unit_clause_tracker

Interface
REQ-001 SHALL have parameter W, default 8: number of variables, one pending-unit-clause bit per variable (W >= 2).
REQ-002 SHALL have parameter NDEL, default 2: number of independent delete ports.
REQ-003 SHALL have parameter DEPTH, default 4: save/restore stack entries.
REQ-004 SHALL define derived widths IW = $clog2(W), CW = $clog2(W+1), SW = $clog2(DEPTH+1).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port load_en, input, 1: bulk write of load_data.
REQ-008 SHALL have port load_data, input, W: new pending vector.
REQ-009 SHALL have port set_mask, input, W: bits to OR into the pending vector.
REQ-010 SHALL have port del_en, input, NDEL: per-port delete strobe.
REQ-011 SHALL have port del_var, input, NDEL*IW: packed per-port variable index; port k occupies bits [k*IW +: IW].
REQ-012 SHALL have port save, input, 1: push the current vector onto the stack.
REQ-013 SHALL have port restore, input, 1: pop the stack top into the vector.
REQ-014 SHALL have port unit_clause, output, W: the current pending vector, driven directly from the register.
REQ-015 SHALL have ports out_valid (output, 1), out_var (output, IW), out_ready (input, 1): pop handshake for the lowest-index pending variable.
REQ-016 SHALL have port count, output, CW: population count of unit_clause.
REQ-017 SHALL have port level, output, SW: number of occupied stack entries.
REQ-018 SHALL have ports overflow and underflow, output, 1 each: sticky error flags.

Function
REQ-019 SHALL drive out_valid = |unit_clause and out_var = the index of the lowest set bit, combinationally from the register; out_var SHALL be 0 when out_valid = 0.
REQ-020 SHALL perform a pop when out_valid && out_ready; the popped bit SHALL clear at the next edge.
REQ-021 SHALL drive count combinationally from the register (0..W).
REQ-022 SHALL compute the normal next value as (uc | set_mask) & ~clr, where clr = the union of all enabled, in-range del_var bits and the popped bit. Clear SHALL win over set on the same bit.
REQ-023 SHALL ignore a delete whose index is >= W.
REQ-024 SHALL treat duplicate indices across delete ports as a single clear.
REQ-025 SHALL use next = load_data when load_en = 1; set_mask, deletes and pop SHALL be ignored that cycle. out_ready SHALL still be accepted and the pop lost, so drivers must not pop while loading.
REQ-026 SHALL, when restore = 1 and level > 0, set uc <= stack[level-1] and level <= level-1. This SHALL override load, set, delete, pop and save in the same cycle.
REQ-027 SHALL, when restore = 1 and level = 0, leave uc and level unchanged and set underflow; the normal or load update SHALL still apply.
REQ-028 SHALL, when save = 1, restore = 0 and level < DEPTH, store the pre-edge uc at stack[level] and set level <= level+1. The same-cycle load/set/delete/pop SHALL still update uc.
REQ-029 SHALL, when save = 1 and level = DEPTH, not push and set overflow; the uc update SHALL proceed.
REQ-030 SHALL keep overflow and underflow set until reset.
REQ-031 SHALL update all state with 1-cycle latency; outputs SHALL reflect the new state immediately after the edge.

Reset
REQ-032 SHALL, while rst = 1 (asynchronous, active-high), force uc = 0, level = 0, overflow = 0 and underflow = 0. Consequently out_valid = 0, out_var = 0 and count = 0.
REQ-033 SHALL leave stack contents unreset; entries SHALL be unreadable until pushed.
REQ-034 SHALL, on reset asserted mid-operation, take effect without a clock edge and discard any in-flight save, restore or pop.

Verification
REQ-035 SHALL verify: W=8, load_data=8'hFF, then del_en=2'b11, del_var={3'd6,3'd2} -> unit_clause=8'hBB, count=6.
REQ-036 SHALL verify: uc=8'b0010_1000, out_ready=1 for 3 cycles -> out_var 3 then 5, then out_valid=0, uc=0.
REQ-037 SHALL verify: set_mask=8'h01 with delete of var 0 in the same cycle -> bit 0 stays 0.
REQ-038 SHALL verify: uc=8'h0F, save, load 8'hF0, restore -> uc=8'h0F, level 1 -> 0.
REQ-039 SHALL verify: DEPTH=4, 5 saves -> level=4, overflow=1; 5 restores -> level=0, underflow=1; both flags clear only on rst.
REQ-040 SHALL verify: rst pulsed between clock edges with uc=8'hAA, level=2 -> uc=0 and level=0 before the next edge.
